// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_pkg                                                       |
// | Purpose  : Shared types and constants for the SPI serial-clock generator.|
// |            Holds the generator state enum, the four {cpol,cpha} mode     |
// |            encodings and the default burst length loaded at reset.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned SPI_RST_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/sclk_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sclk_prescaler                                                |
// | Purpose  : Half-period prescaler. Counts 0..i_div while enabled and      |
// |            issues a one-cycle terminal-count tick, then wraps to 0.      |
// | Ports    : i_clk, i_rst_n (sync, active-low)                             |
// |            i_clr  - force count to 0 (priority over enable)              |
// |            i_en   - advance the count                                    |
// |            i_div  - terminal count (half-period = i_div+1 cycles)        |
// |            o_tick - terminal count reached this cycle while enabled      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sclk_prescaler
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             w_tc;

  // Comparing against i_div (rather than counting to overflow) keeps the
  // all-ones divisor exact: 2^DIV_W cycles, wrap only after the tick.
  assign w_tc   = (cnt_q == i_div);
  assign o_tick = i_en & ~i_clr & w_tc;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = w_tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_sclk_gen                                                  |
// | Purpose  : SPI serial-clock burst generator. Produces 2*bits SCLK edges  |
// |            at a programmable half-period in any CPOL/CPHA mode, with     |
// |            per-edge sample/shift strobes one i_clk ahead of each edge.   |
// | Ports    : i_clk, i_rst_n (sync, active-low)                             |
// |            i_cfg_valid/div/cpol/cpha/bits - config, latched in IDLE      |
// |            i_start   - start a burst (IDLE only)                         |
// |            o_busy    - RUN or DONE                                       |
// |            o_sclk    - registered SCLK                                   |
// |            o_sample / o_shift - SCLK edge of that kind at next i_clk     |
// |            o_bit_idx - current bit index, 0-based                        |
// |            o_done    - one-cycle pulse at burst end                      |
// | Options  : SPI_SCLK_CHAIN_EN - i_start in DONE chains the next burst     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned RST_BITS = SPI_RST_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_cfg_cpol,
  input  logic             i_cfg_cpha,
  input  logic [CNT_W-1:0] i_cfg_bits,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_sclk,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W-1:0] o_bit_idx,
  output logic             o_done
);

  state_e           state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic             cpol_q,    cpol_d;
  logic             cpha_q,    cpha_d;
  logic [CNT_W-1:0] bits_q,    bits_d;
  logic             sclk_q,    sclk_d;
  logic [CNT_W:0]   edge_q,    edge_d;     // edges already issued this burst
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;

  logic             w_tick;
  logic             w_clr;
  logic             w_run;
  logic             w_leading;
  logic             w_last_edge;
  logic [CNT_W:0]   w_edge_last;
  logic [1:0]       w_mode;
  logic             w_sample_on_lead;

  sclk_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_run),
    .i_div   (div_q),
    .o_tick  (w_tick)
  );

  assign w_run       = (state_q == ST_RUN);
  // Even edge numbers (0, 2, ...) are leading edges.
  assign w_leading   = ~edge_q[0];
  assign w_edge_last = {bits_q, 1'b0} - (CNT_W+1)'(1);
  assign w_last_edge = (edge_q == w_edge_last);

  assign w_mode           = {cpol_q, cpha_q};
  assign w_sample_on_lead = (w_mode == MODE0) || (w_mode == MODE2);

  // Strobes fire in the terminal-count cycle, one i_clk ahead of the
  // registered SCLK edge they announce.
  assign o_sample = w_tick & (w_leading == w_sample_on_lead);
  assign o_shift  = w_tick & (w_leading != w_sample_on_lead);

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_DONE);
  assign o_sclk    = sclk_q;
  assign o_bit_idx = bit_idx_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    bits_d    = bits_q;
    sclk_d    = sclk_q;
    edge_d    = edge_q;
    bit_idx_d = bit_idx_q;
    w_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          div_d  = i_cfg_div;
          cpol_d = i_cfg_cpol;
          cpha_d = i_cfg_cpha;
          bits_d = (i_cfg_bits == '0) ? CNT_W'(1) : i_cfg_bits;
        end
        // Idle level tracks the config being written this cycle so a
        // simultaneous latch+start begins from the new polarity.
        sclk_d = i_cfg_valid ? i_cfg_cpol : cpol_q;
        if (i_start) begin
          w_clr     = 1'b1;
          edge_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + (CNT_W+1)'(1);
          if (w_last_edge) begin
            state_d = ST_DONE;
          end else if (!w_leading) begin
            bit_idx_d = bit_idx_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef SPI_SCLK_CHAIN_EN
        if (i_start) begin
          w_clr     = 1'b1;
          edge_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_RUN;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bits_q    <= CNT_W'(RST_BITS);
      sclk_q    <= 1'b0;
      edge_q    <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      bits_q    <= bits_d;
      sclk_q    <= sclk_d;
      edge_q    <= edge_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_sclk_gen                                               |
// | Purpose  : Directed self-checking bench for spi_sclk_gen. Inputs change  |
// |            1 time unit after the rising edge; outputs are read there.    |
// | Options  : SPI_SCLK_CHAIN_EN selects the chaining expectation.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_sclk_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_cpol;
  logic       cfg_cpha;
  logic [4:0] cfg_bits;
  logic       start;
  logic       busy;
  logic       sclk;
  logic       sample;
  logic       shift;
  logic [4:0] bit_idx;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_sclk_gen #(
    .DIV_W    (8),
    .CNT_W    (5),
    .RST_BITS (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .i_cfg_cpol  (cfg_cpol),
    .i_cfg_cpha  (cfg_cpha),
    .i_cfg_bits  (cfg_bits),
    .i_start     (start),
    .o_busy      (busy),
    .o_sclk      (sclk),
    .o_sample    (sample),
    .o_shift     (shift),
    .o_bit_idx   (bit_idx),
    .o_done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++; if (busy    !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (sclk    !== 1'b0) begin n_err++; $display("FAIL rst_sclk got %b exp 0", sclk); end
    n_vec++; if (sample  !== 1'b0) begin n_err++; $display("FAIL rst_sample got %b exp 0", sample); end
    n_vec++; if (shift   !== 1'b0) begin n_err++; $display("FAIL rst_shift got %b exp 0", shift); end
    n_vec++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL rst_bit_idx got %0d exp 0", bit_idx); end
    n_vec++; if (done    !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
  endtask

  // Reset defaults: div=0, bits=8, mode 0.
  task automatic test_mode0_div0();
    int   toggles;
    int   samples;
    logic prev;
    toggles = 0;
    samples = 0;
    prev    = sclk;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL m0_busy k=%0d got %b exp 1", k, busy); end
      n_vec++; if (sclk !== k[0]) begin n_err++; $display("FAIL m0_sclk k=%0d got %b exp %b", k, sclk, k[0]); end
      n_vec++; if (sample !== ~k[0]) begin n_err++; $display("FAIL m0_sample k=%0d got %b exp %b", k, sample, ~k[0]); end
      n_vec++; if (shift !== k[0]) begin n_err++; $display("FAIL m0_shift k=%0d got %b exp %b", k, shift, k[0]); end
      n_vec++; if (bit_idx !== 5'(k/2)) begin n_err++; $display("FAIL m0_bit_idx k=%0d got %0d exp %0d", k, bit_idx, k/2); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL m0_done_early k=%0d got %b exp 0", k, done); end
      if (sclk !== prev) toggles++;
      prev = sclk;
      if (sample === 1'b1) samples++;
      tick();
    end
    if (sclk !== prev) toggles++;
    // 17 cycles after the start cycle
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL m0_done got %b exp 1", done); end
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL m0_sclk_end got %b exp 0", sclk); end
    n_vec++; if (sample !== 1'b0) begin n_err++; $display("FAIL m0_sample_done got %b exp 0", sample); end
    n_vec++; if (bit_idx !== 5'd7) begin n_err++; $display("FAIL m0_bit_idx_end got %0d exp 7", bit_idx); end
    n_vec++; if (toggles !== 16) begin n_err++; $display("FAIL m0_toggles got %0d exp 16", toggles); end
    n_vec++; if (samples !== 8) begin n_err++; $display("FAIL m0_samples got %0d exp 8", samples); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m0_idle_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL m0_idle_done got %b exp 0", done); end
  endtask

  task automatic test_mode3_div3();
    int   first_shift;
    int   e;
    logic tc;
    logic lead;
    first_shift = -1;
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_bits = 5'd4;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL m3_idle_sclk got %b exp 1", sclk); end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      e    = k / 4;
      tc   = ((k % 4) == 3);
      lead = ((e % 2) == 0);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL m3_busy k=%0d got %b exp 1", k, busy); end
      n_vec++; if (sclk !== ~e[0]) begin n_err++; $display("FAIL m3_sclk k=%0d got %b exp %b", k, sclk, ~e[0]); end
      n_vec++; if (shift !== (tc & lead)) begin n_err++; $display("FAIL m3_shift k=%0d got %b exp %b", k, shift, tc & lead); end
      n_vec++; if (sample !== (tc & ~lead)) begin n_err++; $display("FAIL m3_sample k=%0d got %b exp %b", k, sample, tc & ~lead); end
      n_vec++; if (bit_idx !== 5'(k/8)) begin n_err++; $display("FAIL m3_bit_idx k=%0d got %0d exp %0d", k, bit_idx, k/8); end
      if (shift === 1'b1 && first_shift < 0) first_shift = k;
      tick();
    end
    n_vec++; if (first_shift !== 3) begin n_err++; $display("FAIL m3_first_shift got %0d exp 3", first_shift); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL m3_done got %b exp 1", done); end
    n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL m3_sclk_end got %b exp 1", sclk); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m3_idle_busy got %b exp 0", busy); end
    n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL m3_idle_sclk_end got %b exp 1", sclk); end
  endtask

  task automatic test_bits0();
    int   toggles;
    int   run_cyc;
    logic prev;
    toggles = 0;
    run_cyc = 0;
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_bits = 5'd0;
    tick();
    cfg_valid = 1'b0;
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL b0_idle_sclk got %b exp 0", sclk); end
    prev  = sclk;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sclk !== prev) toggles++;
      prev = sclk;
      n_vec++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL b0_bit_idx k=%0d got %0d exp 0", k, bit_idx); end
      if (done === 1'b1) break;
      run_cyc++;
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b0_done_timeout got %b exp 1", done); end
    n_vec++; if (run_cyc !== 2) begin n_err++; $display("FAIL b0_run_cycles got %0d exp 2", run_cyc); end
    n_vec++; if (toggles !== 2) begin n_err++; $display("FAIL b0_edges got %0d exp 2", toggles); end
    tick();
  endtask

  // Config and start in the same cycle; a start mid-RUN must not disturb it.
  task automatic test_cfg_with_start();
    int   e;
    logic tc;
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_bits = 5'd2;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      start = (k == 2);
      e  = k / 2;
      tc = k[0];
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cs_busy k=%0d got %b exp 1", k, busy); end
      n_vec++; if (sclk !== e[0]) begin n_err++; $display("FAIL cs_sclk k=%0d got %b exp %b", k, sclk, e[0]); end
      n_vec++; if (sample !== (tc & ~e[0])) begin n_err++; $display("FAIL cs_sample k=%0d got %b exp %b", k, sample, tc & ~e[0]); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL cs_done_early k=%0d got %b exp 0", k, done); end
      tick();
    end
    start = 1'b0;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL cs_done got %b exp 1", done); end
    n_vec++; if (bit_idx !== 5'd1) begin n_err++; $display("FAIL cs_bit_idx got %0d exp 1", bit_idx); end
    tick();
  endtask

  task automatic test_reset_midburst();
    int cyc;
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_bits = 5'd8;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    // Edge 5 (a leading edge) is being produced in this cycle.
    n_vec++; if (sample !== 1'b1) begin n_err++; $display("FAIL rm_edge5_sample got %b exp 1", sample); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b exp 0", busy); end
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL rm_sclk got %b exp 0", sclk); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rm_done got %b exp 0", done); end
    n_vec++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL rm_bit_idx got %0d exp 0", bit_idx); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rm_done_after got %b exp 0", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) break;
      tick();
      cyc++;
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rm_rerun_timeout got %b exp 1", done); end
    n_vec++; if (cyc !== 17) begin n_err++; $display("FAIL rm_rerun_len got %0d exp 17", cyc); end
    tick();
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_bits = 5'd2;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_busy1 k=%0d got %b exp 1", k, busy); end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bb_done1 got %b exp 1", done); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_done1_busy got %b exp 1", busy); end
    tick();
`ifdef SPI_SCLK_CHAIN_EN
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_chain_busy got %b exp 1", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL bb_chain_done got %b exp 0", done); end
    start = 1'b0;
`else
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bb_gap_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL bb_gap_done got %b exp 0", done); end
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_restart_busy got %b exp 1", busy); end
    start = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_busy2 k=%0d got %b exp 1", k, busy); end
      n_vec++; if (sclk !== k[0]) begin n_err++; $display("FAIL bb_sclk2 k=%0d got %b exp %b", k, sclk, k[0]); end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bb_done2 got %b exp 1", done); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bb_end_busy got %b exp 0", busy); end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_cpol  = 1'b0;
    cfg_cpha  = 1'b0;
    cfg_bits  = 5'd0;
    start     = 1'b0;
    test_reset();
    test_mode0_div0();
    test_mode3_div3();
    test_bits0();
    test_cfg_with_start();
    test_reset_midburst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
